conv1_adder_sched: RTL and testbench

- Sequencer for the convolution stage 1 datapath: multiplier stage followed by the adder-tree stages (stage 1, stage 2, stage 3).
- Counts incoming pixels of one feature map and decides which accepted pixels complete a valid KSIZE x KSIZE window.
- Drives the per-stage enables, with a valid tag travelling alongside the pipeline, and reports output coordinates plus a done pulse.
- Sits between the pixel source / line buffer and the output feature-map writer.

---
 rtl/conv1_adder_sched.sv | 172 +++++++++++++++++
 tb/tb_conv1_adder_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_adder_sched.sv
// Convolution stage-1 sequencer: counts input pixels, tags window-completing accepts through the
// mult/adder pipeline and reports output coordinates. Optional stall counter: CONV1_STALL_CNT_EN.
module conv1_adder_sched #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int KSIZE      = 3,
  parameter int PIPE_DEPTH = 4,
  localparam int OUT_W = IMG_W - KSIZE + 1,
  localparam int OUT_H = IMG_H - KSIZE + 1,
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  win_shift,
  output logic [PIPE_DEPTH-1:0] stage_en,
  output logic                  out_valid,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  // state | meaning
  // IDLE  | waiting for start, nothing accepted
  // FILL  | accepting pixels, no complete window yet
  // RUN   | accepting pixels, datapath enabled
  // DRAIN | input closed, flushing PIPE_DEPTH stages
  // DONE  | one-cycle completion pulse

  localparam int IN_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int IN_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DR_W  = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IN_CW-1:0]      in_col;
  logic [IN_RW-1:0]      in_row;
  logic [DR_W-1:0]       drain_cnt;
  logic [PIPE_DEPTH-1:0] tag;
  logic                  active;
  logic                  accept;
  logic                  win_hit;
  logic                  last_px;
  logic                  start_go;

  assign accept    = pix_valid & pix_ready;
  assign win_shift = accept;
  assign win_hit   = accept & (in_row >= IN_RW'(KSIZE - 1)) & (in_col >= IN_CW'(KSIZE - 1));
  assign last_px   = (in_row == IN_RW'(IMG_H - 1)) & (in_col == IN_CW'(IMG_W - 1));
  assign start_go  = (state == ST_IDLE) & start & ~abort;
  assign out_valid = tag[PIPE_DEPTH-1] & active;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_FILL;
        // the very last pixel can also be the first window hit (single-window maps)
        ST_FILL: begin
          if (accept && last_px)  state_nxt = ST_DRAIN;
          else if (win_hit)       state_nxt = ST_RUN;
        end
        ST_RUN:   if (accept && last_px) state_nxt = ST_DRAIN;
        ST_DRAIN: if (drain_cnt == DR_W'(PIPE_DEPTH - 1)) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pix_ready <= 1'b0;
      stage_en  <= '0;
      active    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pix_ready <= (state_nxt == ST_FILL) || (state_nxt == ST_RUN);
      stage_en  <= {PIPE_DEPTH{(state_nxt == ST_RUN) || (state_nxt == ST_DRAIN)}};
      active    <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      drain_cnt <= '0;
    end else if (start_go) begin
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        if (in_col == IN_CW'(IMG_W - 1)) begin
          in_col <= '0;
          in_row <= (in_row == IN_RW'(IMG_H - 1)) ? '0 : in_row + IN_RW'(1);
        end else begin
          in_col <= in_col + IN_CW'(1);
        end
      end
      if (out_valid) begin
        if (out_col == COL_W'(OUT_W - 1)) begin
          out_col <= '0;
          out_row <= (out_row == ROW_W'(OUT_H - 1)) ? '0 : out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
      end
      if ((state_nxt == ST_DRAIN) && (state != ST_DRAIN)) begin
        drain_cnt <= '0;
      end else if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + DR_W'(1);
      end
    end
  end

  // Gaps shift a zero tag in, so out_valid keeps the source's gap pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else if (abort) begin
      tag <= '0;
    end else begin
      tag[0] <= win_hit;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

`ifdef CONV1_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_go) begin
      stall_cnt <= '0;
    end else if ((state == ST_RUN) && !pix_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_conv1_adder_sched.sv
// Scoreboard bench for conv1_adder_sched: a 5x5/K3/PD4 instance with randomized source gaps and
// a 3x3/K3/PD1 instance for the single-window case.
module tb_conv1_adder_sched;
  localparam int W = 5, H = 5, K = 3, PD = 4, NPIX = W * H;
  localparam int FIRST_RUN = (K - 1) * W + K;  // accepts seen once RUN is entered

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start, abort, pix_valid;
  logic pix_ready, win_shift, out_valid, busy, done;
  logic [PD-1:0] stage_en;
  logic [1:0] out_row, out_col;
  logic [15:0] stall_cnt;

  logic s_start, s_abort, s_pix_valid;
  logic s_pix_ready, s_win_shift, s_out_valid, s_busy, s_done;
  logic [0:0] s_stage_en, s_out_row, s_out_col;
  logic [15:0] s_stall_cnt;

  conv1_adder_sched #(.IMG_W(W), .IMG_H(H), .KSIZE(K), .PIPE_DEPTH(PD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_shift(win_shift), .stage_en(stage_en), .out_valid(out_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done), .stall_cnt(stall_cnt));

  conv1_adder_sched #(.IMG_W(3), .IMG_H(3), .KSIZE(3), .PIPE_DEPTH(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .pix_valid(s_pix_valid),
    .pix_ready(s_pix_ready), .win_shift(s_win_shift), .stage_en(s_stage_en),
    .out_valid(s_out_valid), .out_row(s_out_row), .out_col(s_out_col), .busy(s_busy),
    .done(s_done), .stall_cnt(s_stall_cnt));

  int checks = 0, failures = 0;
  typedef struct {int row; int col; int due;} exp_t;
  exp_t exp_q[$];
  int   done_q[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  // Monitor: every out_valid/done pulse is matched against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_spurious @cycle %0d: got row=%0d col=%0d expected no output", cyc, out_row, out_col);
      end else begin
        e = exp_q.pop_front();
        if (int'(out_row) != e.row || int'(out_col) != e.col || cyc != e.due) begin
          failures++;
          $display("FAIL out_match: got row=%0d col=%0d cycle=%0d expected row=%0d col=%0d cycle=%0d",
                   out_row, out_col, cyc, e.row, e.col, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      checks++;
      failures++;
      e = exp_q.pop_front();
      $display("FAIL out_missing @cycle %0d: got none expected row=%0d col=%0d", cyc, e.row, e.col);
    end
    if (done) begin
      checks++;
      if (done_q.size() == 0 || done_q[0] != cyc) begin
        failures++;
        $display("FAIL done_timing: got pulse at cycle %0d expected cycle %0d", cyc,
                 (done_q.size() > 0) ? done_q[0] : -1);
      end
      if (done_q.size() > 0) void'(done_q.pop_front());
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      checks++;
      failures++;
      $display("FAIL done_missing @cycle %0d: got 0 expected pulse at %0d", cyc, done_q[0]);
      void'(done_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // gap_mode: 0 continuous, 1 alternating 1/0, 2 random. abort_at < 0 disables abort.
  task automatic run_map(input int gap_mode, input int abort_at, input bit start_busy,
                         input bit reset_in_drain);
    int sent, stall_exp, guard;
    bit pv, tog;
    sent = 0; stall_exp = 0; tog = 1'b0;
    start = 1'b1; pix_valid = 1'b0;
    step();
    start = 1'b0;
    while (sent < NPIX) begin
      if (abort_at >= 0 && sent == abort_at) begin
        abort = 1'b1; pix_valid = 1'b0;
        step();
        abort = 1'b0;
        exp_q.delete(); done_q.delete();
        @(negedge clk);
        chk("abort_ready", pix_ready, 0);
        chk("abort_stage_en", int'(stage_en), 0);
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          pix_valid = 1'b1;
          @(negedge clk);
          chk("abort_idle_shift", win_shift, 0);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        return;
      end
      case (gap_mode)
        0:       pv = 1'b1;
        1:       begin pv = ~tog; tog = ~tog; end
        default: pv = ($urandom_range(0, 3) != 0);
      endcase
      pix_valid = pv;
      if (start_busy && sent == 15) start = 1'b1;
      @(negedge clk);
      chk("win_shift", win_shift, int'(pv));
      chk("pix_ready", pix_ready, 1);
      chk("stage_en", int'(stage_en), (sent >= FIRST_RUN) ? (1 << PD) - 1 : 0);
      if (pv) begin
        if (sent / W >= K - 1 && sent % W >= K - 1)
          exp_q.push_back('{sent / W - (K - 1), sent % W - (K - 1), cyc + PD});
        if (sent == NPIX - 1) done_q.push_back(cyc + PD + 1);
        sent++;
      end else if (sent >= FIRST_RUN) begin
        stall_exp++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0) && guard < 60) begin
      pix_valid = $urandom_range(0, 1);
      if (guard == 2 && reset_in_drain) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stage_en", int'(stage_en), 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", pix_ready, 0);
        exp_q.delete(); done_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix_valid = 1'b0;
        return;
      end
      @(negedge clk);
      chk("drain_no_shift", win_shift, 0);
      if (guard < PD) chk("drain_stage_en", int'(stage_en), (1 << PD) - 1);
      @(posedge clk); #1;
      guard++;
    end
    pix_valid = 1'b0;
    if (guard >= 60) begin
      checks++; failures++;
      $display("FAIL map_timeout: got %0d outputs pending expected 0", exp_q.size());
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
`ifdef CONV1_STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), stall_exp);
`else
    chk("stall_cnt", int'(stall_cnt), 0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_ready", pix_ready, 0);
    chk("reset_stage_en", int'(stage_en), 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", int'(stall_cnt), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      @(negedge clk);
      chk("idle_no_shift", win_shift, 0);
      step();
    end
    pix_valid = 1'b0;

    run_map(0, -1, 1'b0, 1'b0);
    run_map(1, -1, 1'b0, 1'b0);
    run_map(0, 15, 1'b0, 1'b0);
    run_map(0, -1, 1'b0, 1'b0);
    run_map(2, -1, 1'b1, 1'b0);
    run_map(0, -1, 1'b0, 1'b1);
    run_map(2, -1, 1'b0, 1'b0);

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_beats_start", busy, 0);
    step();

    // single-window map, one-stage pipe
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_pix_valid = 1'b1;
      @(negedge clk);
      chk("small_shift", s_win_shift, 1);
      chk("small_no_early_out", s_out_valid, 0);
      step();
    end
    s_pix_valid = 1'b0;
    @(negedge clk);
    chk("small_out_valid", s_out_valid, 1);
    chk("small_out_row", int'(s_out_row), 0);
    chk("small_out_col", int'(s_out_col), 0);
    chk("small_done_early", s_done, 0);
    step();
    @(negedge clk);
    chk("small_done", s_done, 1);
    chk("small_out_after", s_out_valid, 0);
    step();
    @(negedge clk);
    chk("small_idle", s_busy, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
